// File: rtl/instr_mem_burst.sv
// Handshaked instruction memory: wait states, wrapping critical-word-first bursts, back-pressure.
// Optional parity checking is enabled by defining IMEM_PARITY_EN.
module instr_mem_burst #(
    parameter int DATA_BITS   = 32,
    parameter int ADDR_BITS   = 10,
    parameter int MEM_SIZE    = 1024,
    parameter int WAIT_STATES = 1,
    parameter int BURST_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic                 req_burst,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic                 rsp_last,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 busy,
    output logic                 par_err
);

    localparam int CNT_BITS = $clog2(BURST_LEN) + 1;
    localparam logic [ADDR_BITS-1:0] LOW_MASK = ADDR_BITS'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_req_ready;
    logic                 w_accept;
    logic                 w_load;
    logic [2:0]           r_wait_cnt;
    logic [CNT_BITS-1:0]  r_beat_cnt;
    logic                 r_burst;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_mem [MEM_SIZE];
    logic [DATA_BITS-1:0] r_rsp_data;
    logic                 r_rsp_last;

    logic [ADDR_BITS-1:0] w_load_addr;
    logic                 w_load_burst;
    logic [CNT_BITS-1:0]  w_load_cnt;
    logic                 w_load_last;
    logic [ADDR_BITS-1:0] w_next_addr;
    logic                 w_in_range;

    function automatic logic in_range(input logic [ADDR_BITS-1:0] a);
        return 32'(a) < 32'(MEM_SIZE);
    endfunction

    // With zero wait states the first beat loads on the accepting edge, straight from the request.
    assign w_load_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_load_burst = (r_state == IDLE) ? req_burst : r_burst;
    assign w_load_cnt   = (r_state == IDLE) ? '0        : r_beat_cnt;
    assign w_load_last  = (w_load_cnt == (w_load_burst ? CNT_BITS'(BURST_LEN - 1) : '0));
    assign w_next_addr  = (w_load_addr & ~LOW_MASK) | ((w_load_addr + ADDR_BITS'(1)) & LOW_MASK);
    assign w_in_range   = in_range(w_load_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = !rst;
                if (req_valid && !rst) begin
                    w_accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_load       = 1'b1;
                        w_state_next = STREAM;
                    end else begin
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_wait_cnt == 3'd1) begin
                    w_load       = 1'b1;
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                if (rsp_ready) begin
                    if (r_rsp_last) begin
                        w_state_next = IDLE;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Storage is never reset so program images survive a fetch-side reset.
    always_ff @(posedge clk) begin
        if (wr_en && in_range(wr_addr)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_burst    <= 1'b0;
            r_beat_cnt <= '0;
            r_wait_cnt <= '0;
            r_addr     <= '0;
            r_rsp_data <= '0;
            r_rsp_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_burst    <= req_burst;
                r_beat_cnt <= '0;
                r_wait_cnt <= 3'(WAIT_STATES);
                r_addr     <= req_addr;
            end else if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end
            if (w_load) begin
                r_rsp_data <= w_in_range ? r_mem[w_load_addr] : '0;
                r_rsp_last <= w_load_last;
                r_addr     <= w_next_addr;
                r_beat_cnt <= w_load_cnt + CNT_BITS'(1);
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic r_par [MEM_SIZE];
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (wr_en && in_range(wr_addr)) begin
            r_par[wr_addr] <= ^wr_data;
        end
    end

    // Stored bit makes the word even parity; a mismatch means storage corruption.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_load) begin
            r_par_err <= w_in_range ? ((^r_mem[w_load_addr]) != r_par[w_load_addr]) : 1'b0;
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign req_ready = w_req_ready;
    assign rsp_valid = (r_state == STREAM);
    assign busy      = (r_state != IDLE);
    assign rsp_data  = r_rsp_data;
    assign rsp_last  = r_rsp_last;

endmodule

// File: tb/tb_instr_mem_burst.sv
// Bench for instr_mem_burst: unit 0 has no wait states and a 1000-word store, unit 1 uses defaults.
// Table vectors, hand sequences for corner cases, then randomized requests against a reference model.
module tb_instr_mem_burst;

    localparam int WS0 = 0;
    localparam int WS1 = 1;
    localparam int MS0 = 1000;
    localparam int MS1 = 1024;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic [9:0]  req_addr  [2];
    logic        req_burst [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data  [2];
    logic        rsp_last  [2];
    logic        wr_en     [2];
    logic [9:0]  wr_addr   [2];
    logic [31:0] wr_data   [2];
    logic        busy      [2];
    logic        par_err   [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : gen_dut
        instr_mem_burst #(
            .DATA_BITS  (32),
            .ADDR_BITS  (10),
            .MEM_SIZE   ((gi == 0) ? MS0 : MS1),
            .WAIT_STATES((gi == 0) ? WS0 : WS1),
            .BURST_LEN  (4)
        ) u_dut (
            .clk      (clk),
            .rst      (rst[gi]),
            .req_valid(req_valid[gi]),
            .req_ready(req_ready[gi]),
            .req_addr (req_addr[gi]),
            .req_burst(req_burst[gi]),
            .rsp_valid(rsp_valid[gi]),
            .rsp_ready(rsp_ready[gi]),
            .rsp_data (rsp_data[gi]),
            .rsp_last (rsp_last[gi]),
            .wr_en    (wr_en[gi]),
            .wr_addr  (wr_addr[gi]),
            .wr_data  (wr_data[gi]),
            .busy     (busy[gi]),
            .par_err  (par_err[gi])
        );
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] mdl [2][1024];

    typedef struct {
        int          u;
        int          addr;
        bit          burst;
        int          hold_beat;
        int          hold_cyc;
        logic [31:0] e [4];
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(int u, int a, bit b, int hb, int hc,
                                logic [31:0] e0, logic [31:0] e1, logic [31:0] e2, logic [31:0] e3);
        vec_t v;
        v.u = u; v.addr = a; v.burst = b; v.hold_beat = hb; v.hold_cyc = hc;
        v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
        return v;
    endfunction

    function automatic int ws(int u);
        return (u == 0) ? WS0 : WS1;
    endfunction

    // Reference: words past the implemented size read as zero.
    function automatic logic [31:0] model_rd(int u, int a);
        int ms;
        ms = (u == 0) ? MS0 : MS1;
        return (a < ms) ? mdl[u][a] : 32'd0;
    endfunction

    // Critical word first, wrapping inside the aligned 4-word block.
    function automatic int beat_addr(int a, int b);
        return (a / 4) * 4 + ((a % 4) + b) % 4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wr(input int u, input int a, input logic [31:0] d);
        wr_en[u] = 1'b1; wr_addr[u] = 10'(a); wr_data[u] = d;
        @(posedge clk); #1;
        wr_en[u] = 1'b0;
        mdl[u][a] = d;
    endtask

    // Starts and ends just after a rising edge with the unit idle.
    task automatic run_req(input int u, input int a, input bit b, input int hold_beat, input int hold_cyc,
                           input int stall_pct, input logic [31:0] e [4], input int perr_addr);
        int n;
        int s;
        int ba;
        n = b ? 4 : 1;
        req_valid[u] = 1'b1; req_addr[u] = 10'(a); req_burst[u] = b;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready[u]), 32'd1);
        @(posedge clk); #1;
        req_valid[u] = 1'b0;
        for (int k = 0; k < ws(u); k++) begin
            @(negedge clk);
            chk("valid_in_wait", 32'(rsp_valid[u]), 32'd0);
            chk("busy_in_wait", 32'(busy[u]), 32'd1);
            @(posedge clk); #1;
        end
        for (int bt = 0; bt < n; bt++) begin
            ba = beat_addr(a, bt);
            if (bt == hold_beat) s = hold_cyc;
            else s = ($urandom_range(0, 99) < 32'(stall_pct)) ? int'($urandom_range(1, 3)) : 0;
            for (int c = 0; c <= s; c++) begin
                rsp_ready[u] = (c == s);
                @(negedge clk);
                chk("rsp_valid", 32'(rsp_valid[u]), 32'd1);
                chk("rsp_data", rsp_data[u], e[bt]);
                chk("rsp_last", 32'(rsp_last[u]), 32'(bt == n - 1));
                chk("par_err", 32'(par_err[u]), 32'(ba == perr_addr));
                @(posedge clk); #1;
            end
        end
        rsp_ready[u] = 1'b0;
        @(negedge clk);
        chk("busy_after", 32'(busy[u]), 32'd0);
        chk("valid_after", 32'(rsp_valid[u]), 32'd0);
        chk("req_ready_after", 32'(req_ready[u]), 32'd1);
        @(posedge clk); #1;
        $display("req u=%0d addr=%0d burst=%0d beats=%0d bad_so_far=%0d", u, a, b, n, bad);
    endtask

    task automatic run_model(input int u, input int a, input bit b, input int hold_beat, input int hold_cyc,
                             input int stall_pct, input int perr_addr);
        logic [31:0] e [4];
        for (int k = 0; k < 4; k++) e[k] = model_rd(u, beat_addr(a, k));
        run_req(u, a, b, hold_beat, hold_cyc, stall_pct, e, perr_addr);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; req_valid[u] = 1'b0; req_addr[u] = '0; req_burst[u] = 1'b0;
            rsp_ready[u] = 1'b0; wr_en[u] = 1'b0; wr_addr[u] = '0; wr_data[u] = '0;
        end

        vecs[0] = mk(1, 5,    1'b0, -1, 0, 32'd5,    32'd0,    32'd0,    32'd0);
        vecs[1] = mk(0, 6,    1'b1, -1, 0, 32'd6,    32'd7,    32'd4,    32'd5);
        vecs[2] = mk(0, 6,    1'b1,  1, 3, 32'd6,    32'd7,    32'd4,    32'd5);
        vecs[3] = mk(1, 6,    1'b1, -1, 0, 32'd6,    32'd7,    32'd4,    32'd5);
        vecs[4] = mk(0, 1001, 1'b1, -1, 0, 32'd0,    32'd0,    32'd0,    32'd0);
        vecs[5] = mk(1, 31,   1'b1,  0, 2, 32'd31,   32'd28,   32'd29,   32'd30);
        vecs[6] = mk(0, 99,   1'b0, -1, 0, 32'd99,   32'd0,    32'd0,    32'd0);

        @(posedge clk); #1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_req_ready", 32'(req_ready[u]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[u]), 32'd0);
            chk("rst_rsp_data", rsp_data[u], 32'd0);
            chk("rst_rsp_last", 32'(rsp_last[u]), 32'd0);
            chk("rst_busy", 32'(busy[u]), 32'd0);
            chk("rst_par_err", 32'(par_err[u]), 32'd0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 2; u++) chk("req_ready_release", 32'(req_ready[u]), 32'd1);
        @(posedge clk); #1;

        for (int a = 0; a < 128; a++) begin
            for (int u = 0; u < 2; u++) begin
                wr_en[u] = 1'b1; wr_addr[u] = 10'(a); wr_data[u] = 32'(a);
                mdl[u][a] = 32'(a);
            end
            @(posedge clk); #1;
            wr_en[0] = 1'b0; wr_en[1] = 1'b0;
        end

        for (int i = 0; i < 7; i++) begin
            run_req(vecs[i].u, vecs[i].addr, vecs[i].burst, vecs[i].hold_beat, vecs[i].hold_cyc,
                    0, vecs[i].e, -1);
        end

        // Write landing on the same edge as the beat load of that address.
        req_valid[1] = 1'b1; req_addr[1] = 10'd3; req_burst[1] = 1'b0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wr_en[1] = 1'b1; wr_addr[1] = 10'd3; wr_data[1] = 32'h0000DEAD;
        @(posedge clk); #1;
        wr_en[1] = 1'b0;
        mdl[1][3] = 32'h0000DEAD;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        chk("collide_valid", 32'(rsp_valid[1]), 32'd1);
        chk("collide_old_data", rsp_data[1], 32'd3);
        chk("collide_last", 32'(rsp_last[1]), 32'd1);
        @(posedge clk); #1;
        rsp_ready[1] = 1'b0;
        run_model(1, 3, 1'b0, -1, 0, 0, -1);
        chk("collide_new_model", model_rd(1, 3), 32'h0000DEAD);

        // Writes beyond the implemented size must be dropped.
        wr(0, 1002, 32'h00001234);
        wr(1, 1002, 32'h00001234);
        run_model(0, 1002, 1'b0, -1, 0, 0, -1);
        run_model(1, 1002, 1'b0, -1, 0, 0, -1);

        // Reset after two delivered beats of a burst aborts the rest.
        req_valid[0] = 1'b1; req_addr[0] = 10'd8; req_burst[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("abort_beat0", rsp_data[0], 32'd8);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_beat1", rsp_data[0], 32'd9);
        @(posedge clk); #1;
        rst[0] = 1'b1; rsp_ready[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        run_model(0, 10, 1'b0, -1, 0, 0, -1);

`ifdef IMEM_PARITY_EN
        gen_dut[1].u_dut.r_par[8] = ~gen_dut[1].u_dut.r_par[8];
        run_model(1, 8, 1'b0, -1, 0, 0, 8);
        run_model(1, 9, 1'b0, -1, 0, 0, -1);
`endif

        for (int i = 0; i < 60; i++) begin
            int u;
            int a;
            u = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                wr(u, int'($urandom_range(0, 127)), $urandom);
            end
            if (u == 0 && $urandom_range(0, 7) == 0) a = int'($urandom_range(1000, 1023));
            else a = int'($urandom_range(0, 127));
            run_model(u, a, 1'($urandom_range(0, 1)), -1, 0, 30, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
